dcache_arbiter: RTL and testbench

- Shares one single-port dcache (ap_memory, 1p, byte-masked write) among `CORES` HLS cores.
- Round-robin arbitration picks one request per cycle.
- Read-issue order is kept in a tag FIFO so the returned read data goes back to the core that issued it.
- Sits directly upstream of the dcache model: its `m_*` port drives that model's per-core request port and consumes its `q0`/`q0_vld`.

---
 rtl/dcache_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_dcache_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_arbiter.sv
// ============================================================================
//  Module   : dcache_arbiter
//  Purpose  : Round-robin arbiter sharing one single-port dcache among CORES
//             requesters. A tag FIFO routes read data back to the issuer.
//             Optional macro DCACHE_ARB_PERF_CNT_EN adds per-core counters.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_arbiter #(
    parameter int CORES     = 4,
    parameter int ABITS     = 8,
    parameter int DBITS     = 32,
    parameter int TAG_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce0      [CORES],
    input  logic                 we0      [CORES],
    input  logic [DBITS/8-1:0]   we_mask  [CORES],
    input  logic [ABITS-1:0]     address0 [CORES],
    input  logic [DBITS-1:0]     d0       [CORES],
    output logic                 ready    [CORES],
    output logic [DBITS-1:0]     q0       [CORES],
    output logic                 q0_vld   [CORES],
    output logic                 m_ce0,
    output logic                 m_we0,
    output logic [DBITS/8-1:0]   m_we_mask,
    output logic [ABITS-1:0]     m_address0,
    output logic [DBITS-1:0]     m_d0,
    input  logic                 m_ready,
    input  logic [DBITS-1:0]     m_q0,
    input  logic                 m_q0_vld,
    output logic                 err_underflow
`ifdef DCACHE_ARB_PERF_CNT_EN
    ,
    output logic [31:0]          grant_cnt [CORES],
    output logic [31:0]          stall_cnt [CORES]
`endif
);

    localparam int c_IDXW = (CORES > 1) ? $clog2(CORES) : 1;
    localparam int c_PTRW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int c_CNTW = $clog2(TAG_DEPTH + 1);
    localparam logic [c_CNTW-1:0] c_DEPTH = c_CNTW'(TAG_DEPTH);
    localparam logic [c_IDXW-1:0] c_LAST  = c_IDXW'(CORES - 1);
    localparam logic [c_IDXW:0]   c_NCORE = (c_IDXW + 1)'(CORES);

    logic [c_IDXW-1:0] r_rr_ptr;
    logic [c_IDXW-1:0] r_tags [TAG_DEPTH];
    logic [c_PTRW-1:0] r_wptr;
    logic [c_PTRW-1:0] r_rptr;
    logic [c_CNTW-1:0] r_count;
    logic [DBITS-1:0]  r_q0 [CORES];
    logic              r_q0_vld [CORES];
    logic              r_err;

    logic [CORES-1:0]  w_elig;
    logic [c_IDXW:0]   w_sum;
    logic [c_IDXW-1:0] w_gnt;
    logic [c_IDXW-1:0] w_pop_tag;
    logic              w_found;
    logic              w_room;
    logic              w_empty;
    logic              w_xfer;
    logic              w_push;
    logic              w_bypass;
    logic              w_pop;
    logic              w_store;
    logic              w_deq;
    logic              w_underflow;

    // A return in this cycle frees a slot, so a full FIFO can still take a read.
    assign w_empty = (r_count == '0);
    assign w_room  = (r_count < c_DEPTH) | m_q0_vld;

    always_comb begin
        for (int i = 0; i < CORES; i++) begin
            w_elig[i] = ce0[i] & (we0[i] | w_room);
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_sum   = '0;
        for (int off = 0; off < CORES; off++) begin
            w_sum = {1'b0, r_rr_ptr} + (c_IDXW + 1)'(off);
            if (w_sum >= c_NCORE) begin
                w_sum = w_sum - c_NCORE;
            end
            if (!w_found && w_elig[w_sum[c_IDXW-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_sum[c_IDXW-1:0];
            end
        end
    end

    assign m_ce0  = w_found & ~rst;
    assign w_xfer = m_ce0 & m_ready;

    always_comb begin
        m_we0      = 1'b0;
        m_we_mask  = '0;
        m_address0 = '0;
        m_d0       = '0;
        if (m_ce0) begin
            m_we0      = we0[w_gnt];
            m_we_mask  = we_mask[w_gnt];
            m_address0 = address0[w_gnt];
            m_d0       = d0[w_gnt];
        end
    end

    always_comb begin
        for (int i = 0; i < CORES; i++) begin
            ready[i] = w_xfer && (w_gnt == c_IDXW'(i));
        end
    end

    // Empty FIFO with a same-cycle push and pop hands the new tag straight through.
    assign w_push      = w_xfer & ~m_we0;
    assign w_bypass    = m_q0_vld & w_empty & w_push;
    assign w_pop       = m_q0_vld & (~w_empty | w_push);
    assign w_underflow = m_q0_vld & w_empty & ~w_push;
    assign w_store     = w_push & ~w_bypass;
    assign w_deq       = m_q0_vld & ~w_empty;
    assign w_pop_tag   = w_bypass ? w_gnt : r_tags[r_rptr];

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_tags[r_wptr] <= w_gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
            for (int i = 0; i < CORES; i++) begin
                r_q0[i]     <= '0;
                r_q0_vld[i] <= 1'b0;
            end
        end else begin
            if (w_xfer) begin
                r_rr_ptr <= (w_gnt == c_LAST) ? '0 : w_gnt + 1'b1;
            end
            if (w_store) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_deq) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_store, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_underflow) begin
                r_err <= 1'b1;
            end
            for (int i = 0; i < CORES; i++) begin
                r_q0_vld[i] <= w_pop && (w_pop_tag == c_IDXW'(i));
                if (w_pop && (w_pop_tag == c_IDXW'(i))) begin
                    r_q0[i] <= m_q0;
                end
            end
        end
    end

    for (genvar gi = 0; gi < CORES; gi++) begin : g_out
        assign q0[gi]     = r_q0[gi];
        assign q0_vld[gi] = r_q0_vld[gi] & ~rst;
    end

    assign err_underflow = r_err & ~rst;

`ifdef DCACHE_ARB_PERF_CNT_EN
    logic [31:0] r_grant_cnt [CORES];
    logic [31:0] r_stall_cnt [CORES];

    always_ff @(posedge clk) begin
        for (int i = 0; i < CORES; i++) begin
            if (rst) begin
                r_grant_cnt[i] <= '0;
                r_stall_cnt[i] <= '0;
            end else begin
                if (ready[i]) begin
                    r_grant_cnt[i] <= r_grant_cnt[i] + 32'd1;
                end
                if (ce0[i] && !ready[i]) begin
                    r_stall_cnt[i] <= r_stall_cnt[i] + 32'd1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < CORES; gi++) begin : g_perf
        assign grant_cnt[gi] = r_grant_cnt[gi];
        assign stall_cnt[gi] = r_stall_cnt[gi];
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dcache_arbiter.sv
// ============================================================================
//  Module   : tb_dcache_arbiter
//  Purpose  : Self-checking bench for dcache_arbiter with a latency-3 memory
//             model and a queue-based reference of grant/tag/return rules.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache_arbiter;

    localparam int CORES     = 4;
    localparam int ABITS     = 8;
    localparam int DBITS     = 32;
    localparam int TAG_DEPTH = 4;
    localparam int MW        = DBITS / 8;
    localparam int LAT       = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              ce0      [CORES];
    logic              we0      [CORES];
    logic [MW-1:0]     we_mask  [CORES];
    logic [ABITS-1:0]  address0 [CORES];
    logic [DBITS-1:0]  d0       [CORES];
    logic              ready    [CORES];
    logic [DBITS-1:0]  q0       [CORES];
    logic              q0_vld   [CORES];
    logic              m_ce0;
    logic              m_we0;
    logic [MW-1:0]     m_we_mask;
    logic [ABITS-1:0]  m_address0;
    logic [DBITS-1:0]  m_d0;
    logic              m_ready;
    logic [DBITS-1:0]  m_q0;
    logic              m_q0_vld;
    logic              err_underflow;

    always #5 clk = ~clk;

    dcache_arbiter #(
        .CORES(CORES), .ABITS(ABITS), .DBITS(DBITS), .TAG_DEPTH(TAG_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .ce0(ce0), .we0(we0), .we_mask(we_mask), .address0(address0), .d0(d0),
        .ready(ready), .q0(q0), .q0_vld(q0_vld),
        .m_ce0(m_ce0), .m_we0(m_we0), .m_we_mask(m_we_mask),
        .m_address0(m_address0), .m_d0(m_d0),
        .m_ready(m_ready), .m_q0(m_q0), .m_q0_vld(m_q0_vld),
        .err_underflow(err_underflow)
    );

    typedef struct {
        int               due;
        logic [DBITS-1:0] data;
    } rsp_t;

    int               n_checks = 0;
    int               n_errors = 0;
    int               cyc = 0;
    logic [7:0]       mem [256];
    rsp_t             pend [$];
    bit               mem_hold = 1'b0;
    bit               force_vld = 1'b0;
    logic [DBITS-1:0] force_data = '0;

    int               rr = 0;
    int               tagq [$];
    logic [DBITS-1:0] exp_q0 [CORES];
    logic [CORES-1:0] exp_vld = '0;
    bit               exp_err = 1'b0;
    bit               q0_known = 1'b0;

    logic [CORES-1:0] s_ready;
    logic [CORES-1:0] s_qvld;
    logic             s_mce0;
    logic             s_err;
    logic [ABITS-1:0] s_addr;
    logic [DBITS-1:0] s_q0 [CORES];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [DBITS-1:0] mem_rd(input logic [7:0] a);
        return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
    endfunction

    task automatic idle();
        for (int i = 0; i < CORES; i++) begin
            ce0[i] = 1'b0; we0[i] = 1'b0; we_mask[i] = '0; address0[i] = '0; d0[i] = '0;
        end
    endtask

    task automatic req(input int i, input logic we, input logic [MW-1:0] mask,
                       input logic [ABITS-1:0] a, input logic [DBITS-1:0] d);
        ce0[i] = 1'b1; we0[i] = we; we_mask[i] = mask; address0[i] = a; d0[i] = d;
    endtask

    // One clock: drive memory return, compare against the reference, advance both.
    task automatic tick();
        int               k;
        int               c;
        int               t;
        bit               room;
        logic [CORES-1:0] e_ready;
        m_q0_vld = 1'b0;
        m_q0     = '0;
        if (force_vld) begin
            m_q0_vld = 1'b1;
            m_q0     = force_data;
        end else if (!mem_hold && pend.size() > 0 && pend[0].due <= cyc) begin
            m_q0_vld = 1'b1;
            m_q0     = pend[0].data;
            void'(pend.pop_front());
        end
        @(negedge clk);
        for (int i = 0; i < CORES; i++) begin
            s_ready[i] = ready[i];
            s_qvld[i]  = q0_vld[i];
            s_q0[i]    = q0[i];
        end
        s_mce0 = m_ce0;
        s_err  = err_underflow;
        s_addr = m_address0;

        k = -1;
        if (!rst) begin
            room = (tagq.size() < TAG_DEPTH) || m_q0_vld;
            for (int off = 0; off < CORES; off++) begin
                c = (rr + off) % CORES;
                if (k < 0 && ce0[c] && (we0[c] || room)) k = c;
            end
        end
        e_ready = '0;
        if (k >= 0 && m_ready) e_ready[k] = 1'b1;
        check("m_ce0", s_mce0, (k >= 0));
        check("ready", s_ready, e_ready);
        if (k >= 0) begin
            check("m_we0", m_we0, we0[k]);
            check("m_address0", m_address0, address0[k]);
            if (we0[k]) begin
                check("m_d0", m_d0, d0[k]);
                check("m_we_mask", m_we_mask, we_mask[k]);
            end
        end
        check("q0_vld", s_qvld, rst ? '0 : exp_vld);
        check("err_underflow", s_err, rst ? 1'b0 : exp_err);
        if (q0_known) begin
            for (int i = 0; i < CORES; i++) check("q0", s_q0[i], exp_q0[i]);
        end

        if (m_ce0 && m_ready) begin
            if (m_we0) begin
                for (int b = 0; b < MW; b++)
                    if (m_we_mask[b]) mem[m_address0 + 8'(b)] = m_d0[8*b +: 8];
            end else begin
                pend.push_back('{due: cyc + LAT, data: mem_rd(m_address0)});
            end
        end

        if (rst) begin
            rr = 0;
            tagq.delete();
            exp_vld = '0;
            exp_err = 1'b0;
            for (int i = 0; i < CORES; i++) exp_q0[i] = '0;
            q0_known = 1'b1;
        end else begin
            exp_vld = '0;
            if (k >= 0 && m_ready) begin
                rr = (k + 1) % CORES;
                if (!we0[k]) tagq.push_back(k);
            end
            if (m_q0_vld) begin
                if (tagq.size() > 0) begin
                    t = tagq.pop_front();
                    exp_vld[t] = 1'b1;
                    exp_q0[t]  = m_q0;
                end else begin
                    exp_err = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < CORES; i++) exp_q0[i] = '0;
        idle();
        m_ready  = 1'b1;
        m_q0     = '0;
        m_q0_vld = 1'b0;
        rst      = 1'b1;

        // Reset with every core requesting a write.
        for (int i = 0; i < CORES; i++)
            req(i, 1'b1, 4'b0001, 8'((i + 1) * 16), 32'hA0 + 32'(i));
        repeat (3) begin
            tick();
            check("rst_ready", s_ready, 0);
            check("rst_m_ce0", s_mce0, 0);
        end
        rst = 1'b0;

        // Round-robin over continuous writes.
        for (int n = 0; n < 8; n++) begin
            tick();
            check("rr_grant", s_ready, 64'(1) << (n % CORES));
        end
        check("mem_0x10", mem[8'h10], 8'hA0);
        check("mem_0x20", mem[8'h20], 8'hA1);
        check("mem_0x30", mem[8'h30], 8'hA2);
        check("mem_0x40", mem[8'h40], 8'hA3);
        check("mem_0x11_masked", mem[8'h11], 8'h00);
        idle();

        // Read routing through the tag FIFO.
        {mem[8'h0B], mem[8'h0A], mem[8'h09], mem[8'h08]} = 32'h11223344;
        {mem[8'h0F], mem[8'h0E], mem[8'h0D], mem[8'h0C]} = 32'h55667788;
        req(2, 1'b0, '0, 8'h08, '0);
        tick();
        check("rd_grant2", s_ready, 4'b0100);
        idle();
        req(1, 1'b0, '0, 8'h0C, '0);
        tick();
        check("rd_grant1", s_ready, 4'b0010);
        idle();
        tick();
        tick();
        tick();
        check("rd_vld2", s_qvld, 4'b0100);
        check("rd_q0_2", s_q0[2], 32'h11223344);
        tick();
        check("rd_vld1", s_qvld, 4'b0010);
        check("rd_q0_1", s_q0[1], 32'h55667788);
        tick();
        check("rd_vld_done", s_qvld, 4'b0000);

        // Tag FIFO full: reads stall, writes still flow, a return frees a slot.
        mem_hold = 1'b1;
        req(0, 1'b0, '0, 8'h08, '0);
        repeat (TAG_DEPTH) begin
            tick();
            check("full_fill", s_ready, 4'b0001);
        end
        req(3, 1'b1, 4'hF, 8'h80, 32'hCAFEF00D);
        tick();
        check("full_write_only", s_ready, 4'b1000);
        ce0[3]   = 1'b0;
        mem_hold = 1'b0;
        tick();
        check("full_unblock", s_ready, 4'b0001);
        idle();
        repeat (10) tick();

        // Backpressure: the pointer must not move while m_ready is low.
        m_ready = 1'b0;
        req(1, 1'b1, 4'hF, 8'h50, 32'h12345678);
        req(3, 1'b1, 4'hF, 8'h60, 32'h9ABCDEF0);
        repeat (5) begin
            tick();
            check("bp_ready", s_ready, 4'b0000);
            check("bp_m_ce0", s_mce0, 1'b1);
            check("bp_addr", s_addr, 8'h50);
        end
        m_ready = 1'b1;
        tick();
        check("bp_release", s_ready, 4'b0010);
        tick();
        check("bp_next", s_ready, 4'b1000);
        idle();

        // Underflow: spurious return is dropped and flags a sticky error.
        tick();
        force_vld  = 1'b1;
        force_data = 32'hDEADBEEF;
        tick();
        force_vld = 1'b0;
        tick();
        check("uf_no_vld", s_qvld, 4'b0000);
        check("uf_err", s_err, 1'b1);
        tick();
        tick();
        check("uf_sticky", s_err, 1'b1);
        rst = 1'b1;
        tick();
        check("uf_rst", s_err, 1'b0);
        rst = 1'b0;
        tick();
        check("uf_cleared", s_err, 1'b0);

        // Reset with a read in flight: its late return counts as underflow.
        req(0, 1'b0, '0, 8'h0C, '0);
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("midrst_err", s_err, 1'b1);
        check("midrst_no_vld", s_qvld, 4'b0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Randomized traffic against the reference.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < CORES; i++) begin
                ce0[i]      = 1'($urandom_range(0, 1));
                we0[i]      = 1'($urandom_range(0, 1));
                we_mask[i]  = MW'($urandom);
                address0[i] = ABITS'($urandom);
                d0[i]       = $urandom;
            end
            m_ready  = ($urandom_range(0, 3) != 0);
            mem_hold = ($urandom_range(0, 7) == 0);
            tick();
        end
        idle();
        m_ready  = 1'b1;
        mem_hold = 1'b0;
        repeat (12) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
